fetch_unit: RTL and testbench

- IF stage: owns the PC, issues instruction-bus requests, and produces the fetch_data_t stream consumed by decode and the immediate generator.
- Buffers up to two fetched instructions so a decode stall does not drop a bus response.
- Applies redirects from execute (branch/jal/jalr) and discards the wrong-path response.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 45 ++++
 rtl/fetch_unit.sv | 80 ++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction fetch stage
//   addr_t/word_t  : 64-bit address and 32-bit instruction word
//   fetch_data_t   : {valid, pc, raw_instr} stream handed to decode
//   fetch_entry_t  : one buffered instruction (pc + word)
//   fetch_state_t  : FETCH (normal) / DROP (discard one wrong-path response)
package fetch_unit_pkg;
  typedef logic [63:0] addr_t;
  typedef logic [31:0] word_t;
  localparam addr_t PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  typedef struct packed {
    logic  valid;
    addr_t pc;
    word_t raw_instr;
  } fetch_data_t;
  typedef struct packed {
    addr_t pc;
    word_t raw_instr;
  } fetch_entry_t;
  typedef enum logic {FETCH, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry in-order skid buffer between the instruction bus and decode
//   push/din  : append an entry (ignored when full and not popping)
//   pop       : drop the head (ignored when empty)
//   flush     : empty the queue; wins over push
//   head/count: oldest entry and current occupancy
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d, slot;
  logic pop_ok, push_ok;
  always_comb begin
    pop_ok  = pop && cnt_q != 2'd0;
    // slot is where the new entry lands after the head has shifted out
    slot    = cnt_q - {1'b0, pop_ok};
    push_ok = push && slot != 2'd2;
    e0_d    = pop_ok ? e1_q : e0_q;
    e1_d    = e1_q;
    if (push_ok && slot == 2'd0) e0_d = din;
    if (push_ok && slot == 2'd1) e1_d = din;
    cnt_d   = flush ? 2'd0 : cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end
  assign head  = e0_q;
  assign count = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage - owns the PC, drives the instruction bus, buffers responses
//   ireq_valid/ireq_addr : registered request, held until iresp_data_ok
//   iresp_data_ok/data   : bus response (may arrive in the request's first cycle)
//   stallF               : decode not accepting dataF this cycle
//   redirect_valid/pc    : flush and restart at redirect_pc (word aligned)
//   dataF                : head of the fetch queue
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter addr_t PC_RESET = PC_RESET_DEFAULT,
  parameter int    QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output fetch_data_t dataF
);
  fetch_state_t state_q, state_d;
  addr_t pc_q, pc_d, addr_q, addr_d;
  logic req_q, req_d, push, pop;
  logic [1:0] count;
  logic [2:0] count_nxt;
  fetch_entry_t head;
  assign pop = count != 2'd0 && !stallF;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    push      = 1'b0;
    count_nxt = {1'b0, count};
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~64'd3;
      // a request still waiting must complete on the bus, so remember to drop it
      state_d = (req_q && !iresp_data_ok) ? DROP : FETCH;
      req_d   = 1'b1;
      addr_d  = state_d == FETCH ? pc_d : addr_q;
    end else if (!(req_q && !iresp_data_ok)) begin
      push      = req_q && state_q == FETCH;
      pc_d      = push ? pc_q + 64'd4 : pc_q;
      state_d   = FETCH;
      count_nxt = {1'b0, count} + {2'b0, push} - {2'b0, pop};
      // launch only if the response is guaranteed a queue slot
      req_d     = count_nxt < 3'(QDEPTH);
      addr_d    = pc_d;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end
  fetch_queue u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ('{pc: pc_q, raw_instr: iresp_data}),
    .head  (head),
    .count (count)
  );
  assign ireq_valid = req_q;
  assign ireq_addr  = addr_q;
  assign dataF      = '{valid: count != 2'd0, pc: head.pc, raw_instr: head.raw_instr};
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit with a bus responder model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 0, reset = 1;
  logic ireq_valid, iresp_data_ok = 0, stallF = 0, redirect_valid = 0;
  logic [63:0] ireq_addr, redirect_pc = '0;
  logic [31:0] iresp_data = '0;
  fetch_data_t dataF;

  fetch_unit dut (
    .clk(clk), .reset(reset), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data), .stallF(stallF),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dataF(dataF)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0, pops = 0;
  fetch_entry_t sb[$];
  logic pending_push = 0, busy = 0;
  logic [63:0] model_pc = PC_RESET_DEFAULT, req_addr = '0;
  int epoch = 0, req_ep = 0, delay = 0;
  int stall_pct = 0, redir_pm = 0, max_delay = 0;
  logic fix_delay = 0, spurious = 0, force_redir = 0, exp_noreq = 0, exp_addr_en = 0;
  logic [63:0] force_target = '0, exp_addr = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pick_target();
    case ($urandom_range(2))
      0: return 64'h8000_0000 + 64'($urandom_range(1023));
      1: return 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(31));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic model_reset();
    sb.delete();
    busy = 0;
    pending_push = 0;
    epoch++;
    model_pc = PC_RESET_DEFAULT;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (exp_addr_en) begin
      chk("restart_valid", 128'(ireq_valid), 128'(1'b1));
      chk("restart_addr", 128'(ireq_addr), 128'(exp_addr));
      exp_addr_en = 0;
    end
    if (exp_noreq) chk("stall_backpressure", 128'(ireq_valid), 128'(1'b0));
    stallF = $urandom_range(99) < stall_pct;
    redirect_valid = force_redir || ($urandom_range(999) < redir_pm);
    redirect_pc = force_redir ? force_target : pick_target();
    force_redir = 0;
    iresp_data_ok = 0;
    iresp_data = $urandom;
    if (ireq_valid) begin
      if (!busy) begin
        busy = 1;
        req_addr = ireq_addr;
        req_ep = epoch;
        delay = fix_delay ? max_delay : $urandom_range(max_delay);
      end else chk("addr_stable", 128'(ireq_addr), 128'(req_addr));
      if (delay == 0) iresp_data_ok = 1;
      else delay--;
    end else begin
      if (busy) chk("req_held", 128'(ireq_valid), 128'(1'b1));
      iresp_data_ok = spurious && $urandom_range(3) == 0;
    end
    pending_push = 0;
    if (redirect_valid) begin
      sb.delete();
      epoch++;
      model_pc = redirect_pc & ~64'd3;
    end
    if (ireq_valid && iresp_data_ok) begin
      busy = 0;
      if (!redirect_valid && req_ep == epoch) begin
        chk("fetch_pc", 128'(req_addr), 128'(model_pc));
        model_pc += 64'd4;
        sb.push_back('{pc: req_addr, raw_instr: iresp_data});
        pending_push = 1;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic knobs(input int s, input int r, input int d, input logic f, input logic sp);
    stall_pct = s; redir_pm = r; max_delay = d; fix_delay = f; spurious = sp;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ireq_valid"}, 128'(ireq_valid), 128'(1'b0));
    chk({nm, "_ireq_addr"}, 128'(ireq_addr), 128'd0);
    chk({nm, "_dataF"}, 128'(dataF), 128'd0);
  endtask

  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && !redirect_valid) begin
        chk("dataF_valid", 128'(dataF.valid), 128'((sb.size() - int'(pending_push)) > 0));
        if (sb.size() > 2) chk("queue_overflow", 128'(sb.size()), 128'd2);
        if (dataF.valid && !stallF) begin
          if (sb.size() == 0) chk("unexpected_dataF", 128'(dataF.pc), 128'd0);
          else begin
            e = sb.pop_front();
            chk("dataF_pc", 128'(dataF.pc), 128'(e.pc));
            chk("dataF_instr", 128'(dataF.raw_instr), 128'(e.raw_instr));
            pops++;
          end
        end
      end
    end
  end

  initial begin
    #2 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    exp_addr = PC_RESET_DEFAULT;
    exp_addr_en = 1;
    knobs(0, 0, 0, 0, 0);
    run(20);
    knobs(100, 0, 0, 0, 0);
    run(2);
    exp_noreq = 1;
    run(3);
    exp_noreq = 0;
    knobs(0, 0, 0, 0, 0);
    run(10);
    knobs(0, 0, 3, 1, 1);
    run(20);
    knobs(0, 0, 2, 1, 0);
    for (int i = 0; i < 20 && !busy; i++) cycle();
    force_target = 64'h8000_0100;
    force_redir = 1;
    run(20);
    knobs(30, 30, 3, 0, 1);
    run(3000);
    knobs(60, 80, 2, 0, 1);
    run(1000);
    knobs(0, 0, 3, 1, 0);
    for (int i = 0; i < 20 && !busy; i++) cycle();
    run(1);
    @(negedge clk);
    redirect_valid = 0;
    iresp_data_ok = 0;
    stallF = 0;
    pending_push = 0;
    #3 reset = 1;
    model_reset();
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("held_reset");
    reset = 0;
    model_reset();
    exp_addr = PC_RESET_DEFAULT;
    exp_addr_en = 1;
    knobs(0, 0, 0, 0, 0);
    run(3);
    force_target = 64'h8000_0102;
    force_redir = 1;
    run(1);
    exp_addr = 64'h8000_0100;
    exp_addr_en = 1;
    run(30);
    knobs(0, 0, 0, 0, 0);
    run(5);
    chk("progress", 128'(pops > 1000), 128'(1'b1));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
